// File: rtl/wash_phase_timer.sv
// wash_phase_timer: per-phase 0.1 s timer with limit flags and BCD digits.
// Optional countdown display: define WASH_TIMER_COUNTDOWN_EN.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   state_display[2:0]  washer state code from the control FSM
//   pause               freezes prescaler, counters and flags
//   wash/water/dewater/alarm  sticky limit flags (ST2..ST5)
//   phase_done          one-cycle pulse when the active phase hits limit
//   elapsed[CNT_W-1:0]  binary elapsed tenths in the current phase
//   seg3..seg0          min : 10 s : s : 0.1 s BCD digits
module wash_phase_timer #(
  parameter int TICK_DIV  = 5000000,
  parameter int CNT_W     = 13,
  parameter int WASH_T    = 6000,
  parameter int WATER_T   = 300,
  parameter int DEWATER_T = 3000,
  parameter int ALARM_T   = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       state_display,
  input  logic             pause,
  output logic             wash,
  output logic             water,
  output logic             dewater,
  output logic             alarm,
  output logic             phase_done,
  output logic [CNT_W-1:0] elapsed,
  output logic [3:0]       seg3,
  output logic [3:0]       seg2,
  output logic [3:0]       seg1,
  output logic [3:0]       seg0
);

  typedef enum logic [2:0] {
    ST0 = 3'b001,
    ST1 = 3'b011,
    ST2 = 3'b111,
    ST3 = 3'b110,
    ST4 = 3'b100,
    ST5 = 3'b000
  } state_e;

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(TICK_DIV - 1);

  localparam logic [CNT_W-1:0] LIM_WASH =
    CNT_W'(WASH_T);
  localparam logic [CNT_W-1:0] LIM_WATER =
    CNT_W'(WATER_T);
  localparam logic [CNT_W-1:0] LIM_DEWATER =
    CNT_W'(DEWATER_T);
  localparam logic [CNT_W-1:0] LIM_ALARM =
    CNT_W'(ALARM_T);

  logic [2:0]       prev_q, prev_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] elap_q, elap_d;
  logic [15:0]      dig_q, dig_d;
  logic [3:0]       flag_q, flag_d;
  logic             done_q, done_d;

  logic             change;
  logic             timed;
  logic             zero_st;
  logic [CNT_W-1:0] lim;
  logic [3:0]       fmask;
  logic             tick;
  logic [15:0]      dig_step;
  logic [15:0]      ent_bcd;

`ifdef WASH_TIMER_COUNTDOWN_EN
  function automatic logic [15:0] to_bcd(
    input int v
  );
    int r;
    r = v % 600;
    return {4'(v / 600), 4'(r / 100),
            4'((r % 100) / 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0] BCD_WASH =
    to_bcd(WASH_T);
  localparam logic [15:0] BCD_WATER =
    to_bcd(WATER_T);
  localparam logic [15:0] BCD_DEWATER =
    to_bcd(DEWATER_T);
  localparam logic [15:0] BCD_ALARM =
    to_bcd(ALARM_T);

  // Mixed-radix borrow: 0.1 s and s roll 0->9,
  // 10 s rolls 0->5, minutes just decrement.
  function automatic logic [15:0] bcd_dec(
    input logic [15:0] d
  );
    logic [15:0] r;
    r = d;
    if (d[3:0] != 4'd0) begin
      r[3:0] = d[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (d[7:4] != 4'd0) begin
        r[7:4] = d[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd9;
        if (d[11:8] != 4'd0) begin
          r[11:8] = d[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd5;
          r[15:12] = d[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    ent_bcd = '0;
    unique case (state_display)
      ST2:     ent_bcd = BCD_WASH;
      ST3:     ent_bcd = BCD_WATER;
      ST4:     ent_bcd = BCD_DEWATER;
      ST5:     ent_bcd = BCD_ALARM;
      default: ent_bcd = '0;
    endcase
  end

  assign dig_step = bcd_dec(dig_q);
`else
  // Mixed-radix carry: 0.1 s and s wrap at 9,
  // 10 s wraps at 5, minutes wrap at 9.
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] d
  );
    logic [15:0] r;
    r = d;
    if (d[3:0] != 4'd9) begin
      r[3:0] = d[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (d[7:4] != 4'd9) begin
        r[7:4] = d[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (d[11:8] != 4'd5) begin
          r[11:8] = d[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (d[15:12] != 4'd9)
            r[15:12] = d[15:12] + 4'd1;
          else
            r[15:12] = 4'd0;
        end
      end
    end
    return r;
  endfunction

  assign ent_bcd  = '0;
  assign dig_step = bcd_inc(dig_q);
`endif

  // Per-state limit and flag select.
  always_comb begin
    timed   = 1'b1;
    zero_st = 1'b0;
    lim     = '0;
    fmask   = 4'b0000;
    unique case (state_display)
      ST2: begin
        lim   = LIM_WASH;
        fmask = 4'b0001;
      end
      ST3: begin
        lim   = LIM_WATER;
        fmask = 4'b0010;
      end
      ST4: begin
        lim   = LIM_DEWATER;
        fmask = 4'b0100;
      end
      ST5: begin
        lim   = LIM_ALARM;
        fmask = 4'b1000;
      end
      ST0, ST1: begin
        timed   = 1'b0;
        zero_st = 1'b1;
      end
      default: timed = 1'b0;
    endcase
  end

  assign change = (state_display != prev_q);
  assign tick   = (presc_q == PMAX);

  always_comb begin
    prev_d  = state_display;
    presc_d = presc_q;
    elap_d  = elap_q;
    dig_d   = dig_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    if (change) begin
      presc_d = '0;
      elap_d  = '0;
      dig_d   = ent_bcd;
      flag_d  = '0;
    end else if (zero_st) begin
      presc_d = '0;
      elap_d  = '0;
      dig_d   = '0;
      flag_d  = '0;
    end else if (timed && !pause) begin
      if (elap_q < lim) begin
        if (tick) begin
          presc_d = '0;
          elap_d  = elap_q + 1'b1;
          dig_d   = dig_step;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end else if ((flag_q & fmask) == 4'b0) begin
        // Limit seen: raise flag and pulse once.
        flag_d = fmask;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= ST0;
      presc_q <= '0;
      elap_q  <= '0;
      dig_q   <= '0;
      flag_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      presc_q <= presc_d;
      elap_q  <= elap_d;
      dig_q   <= dig_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign wash       = flag_q[0];
  assign water      = flag_q[1];
  assign dewater    = flag_q[2];
  assign alarm      = flag_q[3];
  assign phase_done = done_q;
  assign elapsed    = elap_q;
  assign seg3       = dig_q[15:12];
  assign seg2       = dig_q[11:8];
  assign seg1       = dig_q[7:4];
  assign seg0       = dig_q[3:0];

endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer: directed checks of wash_phase_timer
// on three parameter sets (tick every 1, 2 and 4 cycles).
module tb_wash_phase_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // A: TICK_DIV=1
  logic        rst_a = 1'b1;
  logic [2:0]  st_a = 3'b001;
  logic        pz_a = 1'b0;
  logic        wash_a, water_a, dewater_a, alarm_a, done_a;
  logic [12:0] el_a;
  logic [3:0]  s3_a, s2_a, s1_a, s0_a;
  logic [15:0] dg_a;
  logic [3:0]  fl_a;
  assign dg_a = {s3_a, s2_a, s1_a, s0_a};
  assign fl_a = {wash_a, water_a, dewater_a, alarm_a};

  // B: TICK_DIV=2
  logic        rst_b = 1'b1;
  logic [2:0]  st_b = 3'b001;
  logic        pz_b = 1'b0;
  logic        wash_b, water_b, dewater_b, alarm_b, done_b;
  logic [12:0] el_b;
  logic [3:0]  s3_b, s2_b, s1_b, s0_b;
  logic [15:0] dg_b;
  logic [3:0]  fl_b;
  assign dg_b = {s3_b, s2_b, s1_b, s0_b};
  assign fl_b = {wash_b, water_b, dewater_b, alarm_b};

  // C: TICK_DIV=4, WATER_T=0
  logic        rst_c = 1'b1;
  logic [2:0]  st_c = 3'b001;
  logic        pz_c = 1'b0;
  logic        wash_c, water_c, dewater_c, alarm_c, done_c;
  logic [12:0] el_c;
  logic [3:0]  s3_c, s2_c, s1_c, s0_c;
  logic [3:0]  fl_c;
  assign fl_c = {wash_c, water_c, dewater_c, alarm_c};

  wash_phase_timer #(
    .TICK_DIV(1), .CNT_W(13), .WASH_T(5999),
    .WATER_T(300), .DEWATER_T(100), .ALARM_T(100)
  ) u_a (
    .clk(clk), .reset(rst_a), .state_display(st_a),
    .pause(pz_a), .wash(wash_a), .water(water_a),
    .dewater(dewater_a), .alarm(alarm_a),
    .phase_done(done_a), .elapsed(el_a),
    .seg3(s3_a), .seg2(s2_a), .seg1(s1_a), .seg0(s0_a)
  );

  wash_phase_timer #(
    .TICK_DIV(2), .CNT_W(13), .WASH_T(6000),
    .WATER_T(25), .DEWATER_T(3000), .ALARM_T(100)
  ) u_b (
    .clk(clk), .reset(rst_b), .state_display(st_b),
    .pause(pz_b), .wash(wash_b), .water(water_b),
    .dewater(dewater_b), .alarm(alarm_b),
    .phase_done(done_b), .elapsed(el_b),
    .seg3(s3_b), .seg2(s2_b), .seg1(s1_b), .seg0(s0_b)
  );

  wash_phase_timer #(
    .TICK_DIV(4), .CNT_W(13), .WASH_T(6000),
    .WATER_T(0), .DEWATER_T(3000), .ALARM_T(10)
  ) u_c (
    .clk(clk), .reset(rst_c), .state_display(st_c),
    .pause(pz_c), .wash(wash_c), .water(water_c),
    .dewater(dewater_c), .alarm(alarm_c),
    .phase_done(done_c), .elapsed(el_c),
    .seg3(s3_c), .seg2(s2_c), .seg1(s1_c), .seg0(s0_c)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    st_b  = 3'b110;
    step(1);
    nvec++;
    if (el_b !== 13'd0) begin
      nerr++;
      $display("FAIL rst_el: got %0d want 0", el_b);
    end
    nvec++;
    if (dg_b !== 16'h0000) begin
      nerr++;
      $display("FAIL rst_dig: got %h want 0000", dg_b);
    end
    nvec++;
    if ({fl_b, done_b} !== 5'b0) begin
      nerr++;
      $display("FAIL rst_flags: got %b want 00000",
               {fl_b, done_b});
    end
  endtask

  task automatic test_drain_limit();
    int npulse = 0;
    int at = -1;
    logic [15:0] dexp;
`ifdef WASH_TIMER_COUNTDOWN_EN
    dexp = 16'h0000;
`else
    dexp = 16'h0025;
`endif
    rst_b = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      step(1);
      if (done_b === 1'b1) begin
        npulse++;
        at = i;
      end
    end
    nvec++;
    if (npulse !== 1) begin
      nerr++;
      $display("FAIL drain_pulses: got %0d want 1", npulse);
    end
    nvec++;
    if (at !== 52) begin
      nerr++;
      $display("FAIL drain_pulse_at: got %0d want 52", at);
    end
    nvec++;
    if (fl_b !== 4'b0100) begin
      nerr++;
      $display("FAIL drain_flags: got %b want 0100", fl_b);
    end
    nvec++;
    if (el_b !== 13'd25) begin
      nerr++;
      $display("FAIL drain_el: got %0d want 25", el_b);
    end
    nvec++;
    if (dg_b !== dexp) begin
      nerr++;
      $display("FAIL drain_dig: got %h want %h", dg_b, dexp);
    end
    step(5);
    nvec++;
    if (el_b !== 13'd25 || dg_b !== dexp) begin
      nerr++;
      $display("FAIL drain_freeze: got %0d/%h want 25/%h",
               el_b, dg_b, dexp);
    end
  endtask

  task automatic test_minute_carry();
    logic [15:0] d599, d600, dend;
`ifdef WASH_TIMER_COUNTDOWN_EN
    d599 = 16'h9000;
    d600 = 16'h8599;
    dend = 16'h0000;
`else
    d599 = 16'h0599;
    d600 = 16'h1000;
    dend = 16'h9599;
`endif
    rst_a = 1'b1;
    st_a  = 3'b111;
    step(1);
    rst_a = 1'b0;
    step(600);
    nvec++;
    if (el_a !== 13'd599 || dg_a !== d599) begin
      nerr++;
      $display("FAIL carry_599: got %0d/%h want 599/%h",
               el_a, dg_a, d599);
    end
    step(1);
    nvec++;
    if (el_a !== 13'd600 || dg_a !== d600) begin
      nerr++;
      $display("FAIL carry_600: got %0d/%h want 600/%h",
               el_a, dg_a, d600);
    end
    step(5399);
    nvec++;
    if (el_a !== 13'd5999 || dg_a !== dend) begin
      nerr++;
      $display("FAIL carry_end: got %0d/%h want 5999/%h",
               el_a, dg_a, dend);
    end
    nvec++;
    if (wash_a !== 1'b0) begin
      nerr++;
      $display("FAIL carry_early_wash: got %b want 0", wash_a);
    end
    step(1);
    nvec++;
    if (fl_a !== 4'b1000 || done_a !== 1'b1) begin
      nerr++;
      $display("FAIL carry_wash: got %b/%b want 1000/1",
               fl_a, done_a);
    end
    step(1);
    nvec++;
    if (done_a !== 1'b0 || el_a !== 13'd5999) begin
      nerr++;
      $display("FAIL carry_hold: got %b/%0d want 0/5999",
               done_a, el_a);
    end
  endtask

  task automatic test_phase_change();
    rst_a = 1'b1;
    st_a  = 3'b100;
    step(1);
    rst_a = 1'b0;
    step(40);
    nvec++;
    if (el_a !== 13'd39 || dewater_a !== 1'b0) begin
      nerr++;
      $display("FAIL spin_el: got %0d/%b want 39/0",
               el_a, dewater_a);
    end
    st_a = 3'b000;
    step(1);
    nvec++;
    if (el_a !== 13'd0 || fl_a !== 4'b0000) begin
      nerr++;
      $display("FAIL chg_clear: got %0d/%b want 0/0000",
               el_a, fl_a);
    end
    step(100);
    nvec++;
    if (el_a !== 13'd100 || alarm_a !== 1'b0) begin
      nerr++;
      $display("FAIL alarm_el: got %0d/%b want 100/0",
               el_a, alarm_a);
    end
    step(1);
    nvec++;
    if (fl_a !== 4'b0001 || done_a !== 1'b1) begin
      nerr++;
      $display("FAIL alarm_flag: got %b/%b want 0001/1",
               fl_a, done_a);
    end
  endtask

  task automatic test_pause();
    int npulse = 0;
    rst_c = 1'b1;
    st_c  = 3'b000;
    step(1);
    rst_c = 1'b0;
    step(13);
    nvec++;
    if (el_c !== 13'd3) begin
      nerr++;
      $display("FAIL pause_pre: got %0d want 3", el_c);
    end
    pz_c = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (done_c === 1'b1) npulse++;
    end
    nvec++;
    if (el_c !== 13'd3 || npulse !== 0) begin
      nerr++;
      $display("FAIL pause_hold: got %0d/%0d want 3/0",
               el_c, npulse);
    end
    pz_c = 1'b0;
    step(27);
    nvec++;
    if (el_c !== 13'd9) begin
      nerr++;
      $display("FAIL pause_r27: got %0d want 9", el_c);
    end
    step(1);
    nvec++;
    if (el_c !== 13'd10 || alarm_c !== 1'b0) begin
      nerr++;
      $display("FAIL pause_r28: got %0d/%b want 10/0",
               el_c, alarm_c);
    end
    step(1);
    nvec++;
    if (alarm_c !== 1'b1 || done_c !== 1'b1) begin
      nerr++;
      $display("FAIL pause_alarm: got %b/%b want 1/1",
               alarm_c, done_c);
    end
  endtask

  task automatic test_pause_change();
    pz_c = 1'b1;
    st_c = 3'b111;
    step(1);
    nvec++;
    if (el_c !== 13'd0 || fl_c !== 4'b0000) begin
      nerr++;
      $display("FAIL pchg_clear: got %0d/%b want 0/0000",
               el_c, fl_c);
    end
    step(5);
    nvec++;
    if (el_c !== 13'd0) begin
      nerr++;
      $display("FAIL pchg_hold: got %0d want 0", el_c);
    end
    pz_c = 1'b0;
    step(4);
    nvec++;
    if (el_c !== 13'd1) begin
      nerr++;
      $display("FAIL pchg_resume: got %0d want 1", el_c);
    end
  endtask

  task automatic test_zero_limit();
    st_c = 3'b110;
    step(1);
    nvec++;
    if (water_c !== 1'b0 || done_c !== 1'b0) begin
      nerr++;
      $display("FAIL zl_entry: got %b/%b want 0/0",
               water_c, done_c);
    end
    step(1);
    nvec++;
    if (fl_c !== 4'b0100 || done_c !== 1'b1) begin
      nerr++;
      $display("FAIL zl_flag: got %b/%b want 0100/1",
               fl_c, done_c);
    end
    step(3);
    nvec++;
    if (done_c !== 1'b0 || el_c !== 13'd0) begin
      nerr++;
      $display("FAIL zl_hold: got %b/%0d want 0/0",
               done_c, el_c);
    end
  endtask

  task automatic test_reset_mid();
    rst_b = 1'b1;
    st_b  = 3'b111;
    step(1);
    rst_b = 1'b0;
    step(75);
    nvec++;
    if (el_b !== 13'd37) begin
      nerr++;
      $display("FAIL mid_el: got %0d want 37", el_b);
    end
    rst_b = 1'b1;
    step(1);
    nvec++;
    if (el_b !== 13'd0 || dg_b !== 16'h0 ||
        {fl_b, done_b} !== 5'b0) begin
      nerr++;
      $display("FAIL mid_rst: got %0d/%h/%b want 0/0000/0",
               el_b, dg_b, {fl_b, done_b});
    end
    rst_b = 1'b0;
    step(3);
    nvec++;
    if (el_b !== 13'd1) begin
      nerr++;
      $display("FAIL mid_restart: got %0d want 1", el_b);
    end
  endtask

  task automatic test_idle_unused();
    st_b = 3'b011;
    step(10);
    nvec++;
    if (el_b !== 13'd0 || dg_b !== 16'h0) begin
      nerr++;
      $display("FAIL fill_hold: got %0d/%h want 0/0000",
               el_b, dg_b);
    end
    st_b = 3'b111;
    step(11);
    nvec++;
    if (el_b !== 13'd5) begin
      nerr++;
      $display("FAIL rinse_again: got %0d want 5", el_b);
    end
    st_b = 3'b010;
    step(7);
    nvec++;
    if (el_b !== 13'd0 || fl_b !== 4'b0) begin
      nerr++;
      $display("FAIL unused: got %0d/%b want 0/0000",
               el_b, fl_b);
    end
  endtask

`ifdef WASH_TIMER_COUNTDOWN_EN
  task automatic test_countdown();
    rst_a = 1'b1;
    st_a  = 3'b110;
    step(1);
    rst_a = 1'b0;
    step(1);
    nvec++;
    if (dg_a !== 16'h0300) begin
      nerr++;
      $display("FAIL cd_load: got %h want 0300", dg_a);
    end
    step(1);
    nvec++;
    if (dg_a !== 16'h0299) begin
      nerr++;
      $display("FAIL cd_first: got %h want 0299", dg_a);
    end
    step(299);
    nvec++;
    if (dg_a !== 16'h0000 || el_a !== 13'd300) begin
      nerr++;
      $display("FAIL cd_end: got %h/%0d want 0000/300",
               dg_a, el_a);
    end
    step(1);
    nvec++;
    if (water_a !== 1'b1) begin
      nerr++;
      $display("FAIL cd_water: got %b want 1", water_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_drain_limit();
    test_minute_carry();
    test_phase_change();
    test_pause();
    test_pause_change();
    test_zero_limit();
    test_reset_mid();
    test_idle_unused();
`ifdef WASH_TIMER_COUNTDOWN_EN
    test_countdown();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
